rgb_blink_ctrl: RTL

Parametrised LED pattern and bootloader-reset controller for the OrangeCrab top level. It drives NUM_CH active-low LED channels from a free-running counter in one of four selectable modes. The user button is synchronised and debounced: a short press cycles the mode, and a long press asserts rsn_n to enter the bootloader. The block sits directly between the board pins and the rest of the top level.

---
 rtl/rgb_blink_ctrl_if.sv | 26 ++
 rtl/rgb_blink_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/rgb_blink_ctrl_if.sv
// Board-pin bundle for the LED/bootloader controller: raw button in,
// active-low LED drives, current mode and bootloader reset request out.
interface rgb_blink_ctrl_if #(
    parameter int NUM_CH = 3
);
    logic              usr_btn;
    logic [NUM_CH-1:0] led_n;
    logic [1:0]        mode;
    logic              rsn_n;

    // Board / top-level side: drives the button, observes the outputs
    modport master (
        output usr_btn,
        input  led_n,
        input  mode,
        input  rsn_n
    );

    // Controller side
    modport slave (
        input  usr_btn,
        output led_n,
        output mode,
        output rsn_n
    );
endinterface

// File: rtl/rgb_blink_ctrl.sv
// LED pattern and bootloader-reset controller. A free-running counter feeds
// one of four display patterns; the debounced user button cycles the mode on
// a short press and requests a bootloader reset on a long press.
module rgb_blink_ctrl #(
    parameter int CNT_W          = 27,
    parameter int NUM_CH         = 3,
    parameter int PWM_W          = 8,
    parameter int DEBOUNCE_CYC   = 48000,
    parameter int LONG_PRESS_CYC = 96000000
) (
    input  logic             clk48,
    input  logic             rst,
    rgb_blink_ctrl_if.slave  pins
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYC + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYC);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_PRESS_CYC - 1);

    logic [CNT_W-1:0]  cnt;
    logic              sync1;
    logic              sync2;
    logic              btn_s;
    logic              btn_db;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_fired;
    logic [1:0]        mode_r;
    logic              rsn_r;
    logic [NUM_CH-1:0] led_r;
    logic [NUM_CH-1:0] on;
    logic [PWM_W-1:0]  tri_lvl;

    logic db_change;
    logic db_accept;
    logic release_evt;
    logic long_fire;

    assign btn_s       = sync2;
    assign db_change   = (btn_s != btn_db);
    assign db_accept   = db_change && (db_cnt == DB_LAST);
    // Accepting a 1 while the debounced level is 0 is the release edge
    assign release_evt = db_accept && btn_s;
    // Fire on the edge where hold_cnt steps onto the threshold
    assign long_fire   = !long_fired && !btn_db && (hold_cnt == HOLD_PRE);

    // Free-running pattern counter
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + 1'b1;
    end

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pins.usr_btn;
            sync2 <= sync1;
        end
    end

    // Debounce: a new level must persist DEBOUNCE_CYC cycles; any reversal restarts
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            btn_db <= 1'b1;
            db_cnt <= '0;
        end else if (db_accept) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else if (db_change) begin
            db_cnt <= db_cnt + 1'b1;
        end else begin
            db_cnt <= '0;
        end
    end

    // Press duration, saturating so it never wraps during very long holds
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst)                      hold_cnt <= '0;
        else if (btn_db)              hold_cnt <= '0;
        else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
    end

    // Long press latches the bootloader request until rst; short release steps the mode
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            long_fired <= 1'b0;
            rsn_r      <= 1'b1;
            mode_r     <= 2'd0;
        end else begin
            if (long_fire) begin
                long_fired <= 1'b1;
                rsn_r      <= 1'b0;
            end
            if (release_evt && !long_fired && !long_fire)
                mode_r <= mode_r + 2'd1;
        end
    end

    // Pattern selection; breathe folds the upper counter bits into a triangle duty
    always_comb begin
        tri_lvl = cnt[CNT_W-1] ? ~cnt[CNT_W-2 -: PWM_W] : cnt[CNT_W-2 -: PWM_W];
        on      = '0;
        case (mode_r)
            2'd0:    on = cnt[CNT_W-1 -: NUM_CH];
            2'd1:    on = {NUM_CH{cnt[PWM_W-1:0] < tri_lvl}};
            2'd2:    on = '1;
            default: on = '0;
        endcase
    end

    // Registered active-low LED drive
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) led_r <= '1;
        else     led_r <= ~on;
    end

    assign pins.led_n = led_r;
    assign pins.mode  = mode_r;
    assign pins.rsn_n = rsn_r;

endmodule
